// File: rtl/solve_pkg.sv
// Shared types and defaults for the solve sequencer and grid-level benches.
// Enums are reused by anything that decodes sequencer status.
package solve_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_RUN,
    S_REPORT
  } state_e;

  typedef enum logic [1:0] {
    ST_SUCCESS = 2'd0,
    ST_FAILURE = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ABORT   = 2'd3
  } status_e;

  localparam int CLR_CYCLES_DEF = 2;
  localparam int CNT_W_DEF      = 32;
  localparam int TIMEOUT_DEF    = 1 << 20;

endpackage

// File: rtl/sat_counter.sv
// Clearable, enabled up-counter that sticks at all-ones.
// Used to count RUN-state cycles of a solve.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/solve_sequencer.sv
// Sequences one grid solve: clear, start pulse, wait for done, report.
// Optional RUN-state timeout enabled by defining SOLVE_TIMEOUT_EN.
module solve_sequencer
  import solve_pkg::*;
#(
  parameter int CLR_CYCLES     = CLR_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_status,
  output logic [CNT_W-1:0] res_cycles,
  output logic             busy,
  output logic             grid_reset,
  output logic             grid_start,
  input  logic             done_success,
  input  logic             done_failure
);

  localparam int CLW = $clog2(CLR_CYCLES + 1);

  state_e           state;
  logic [CLW-1:0]   clr_cnt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             fin;
  status_e          fin_status;

  assign accept = (state == S_IDLE) && req_valid && req_ready;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk    (clock),
    .rst_n  (reset),
    .clear  (accept || (state == S_LAUNCH)),
    .enable (state == S_RUN),
    .count  (cnt)
  );

  // Abort outranks done; success outranks failure; any done outranks timeout.
  always_comb begin
    fin        = 1'b0;
    fin_status = ST_SUCCESS;
    if (abort && (state inside {S_CLEAR, S_LAUNCH, S_RUN})) begin
      fin        = 1'b1;
      fin_status = ST_ABORT;
    end else if (state == S_RUN) begin
      if (done_success) begin
        fin        = 1'b1;
        fin_status = ST_SUCCESS;
      end else if (done_failure) begin
        fin        = 1'b1;
        fin_status = ST_FAILURE;
      end
`ifdef SOLVE_TIMEOUT_EN
      else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        fin        = 1'b1;
        fin_status = ST_TIMEOUT;
      end
`endif
    end
  end

`ifndef SOLVE_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      req_ready  <= 1'b0;
      res_valid  <= 1'b0;
      res_status <= 2'd0;
      res_cycles <= '0;
      busy       <= 1'b0;
      grid_reset <= 1'b1;
      grid_start <= 1'b0;
    end else begin
      grid_start <= 1'b0;
      if (fin) begin
        state      <= S_REPORT;
        res_status <= fin_status;
        res_cycles <= cnt;
        res_valid  <= 1'b1;
        busy       <= 1'b0;
        grid_reset <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            req_ready  <= 1'b1;
            grid_reset <= 1'b1;
            if (accept) begin
              state     <= S_CLEAR;
              req_ready <= 1'b0;
              busy      <= 1'b1;
              clr_cnt   <= CLW'(CLR_CYCLES);
            end
          end
          S_CLEAR: begin
            clr_cnt <= clr_cnt - CLW'(1);
            if (clr_cnt == CLW'(1)) state <= S_LAUNCH;
          end
          S_LAUNCH: begin
            grid_start <= 1'b1;
            grid_reset <= 1'b0;
            state      <= S_RUN;
          end
          S_RUN: begin
            grid_reset <= 1'b0;
          end
          S_REPORT: begin
            if (res_ready) begin
              state     <= S_IDLE;
              res_valid <= 1'b0;
              req_ready <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_solve_sequencer.sv
// Scoreboard bench for solve_sequencer (narrow counter to reach saturation).
// Define SOLVE_TIMEOUT_EN for both DUT and bench to exercise the timeout.
module tb_solve_sequencer;
  import solve_pkg::*;

  localparam int CLR = 2;
  localparam int CW  = 8;
  localparam int TO  = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          abort = 1'b0;
  logic          res_ready = 1'b0;
  logic          done_success = 1'b0;
  logic          done_failure = 1'b0;
  logic          req_ready;
  logic          res_valid;
  logic          busy;
  logic          grid_reset;
  logic          grid_start;
  logic [1:0]    res_status;
  logic [CW-1:0] res_cycles;

  typedef struct {
    logic [1:0] st;
    int         cyc;
    bit         chk_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lat;

  always #5 clock = ~clock;

  solve_sequencer #(
    .CLR_CYCLES     (CLR),
    .CNT_W          (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .abort        (abort),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_status   (res_status),
    .res_cycles   (res_cycles),
    .busy         (busy),
    .grid_reset   (grid_reset),
    .grid_start   (grid_start),
    .done_success (done_success),
    .done_failure (done_failure)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_grid_reset"}, grid_reset, 1);
    check({tag, "_grid_start"}, grid_start, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_res_status"}, res_status, 0);
    check({tag, "_res_cycles"}, res_cycles, 0);
  endtask

  task automatic accept_req();
    int n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_start(output int l);
    l = 0;
    while (!grid_start && l < 20) begin
      tick();
      l++;
    end
    check("start_seen", grid_start, 1);
  endtask

  task automatic get_result(input string tag, input int bound);
    int   n = 0;
    exp_t e;
    while (!res_valid && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_status"}, res_status, e.st);
      if (e.chk_cyc) check({tag, "_cycles"}, res_cycles, e.cyc);
      tick();
      check({tag, "_hold_valid"}, res_valid, 1);
      check({tag, "_hold_status"}, res_status, e.st);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_drop_valid"}, res_valid, 0);
    check({tag, "_idle_ready"}, req_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_reset_vals("rst");
    reset = 1'b1;

    accept_req();
    check("acc_busy", busy, 1);
    check("acc_req_ready", req_ready, 0);
    check("clr_grid_reset", grid_reset, 1);
    wait_start(lat);
    check("start_latency", lat, CLR + 1);
    check("launch_grid_reset", grid_reset, 0);

    sb.push_back('{ST_SUCCESS, 10, 1'b1});
    tick();
    check("start_pulse_one", grid_start, 0);
    repeat (9) tick();
    done_success = 1'b1;
    tick();
    done_success = 1'b0;
    get_result("succ", 0);

    accept_req();
    wait_start(lat);
    sb.push_back('{ST_SUCCESS, 4, 1'b1});
    repeat (4) tick();
    done_success = 1'b1;
    done_failure = 1'b1;
    tick();
    done_success = 1'b0;
    done_failure = 1'b0;
    get_result("both", 0);

    done_success = 1'b1;
    tick();
    done_success = 1'b0;
    done_failure = 1'b1;
    tick();
    done_failure = 1'b0;
    tick();
    check("idle_done_valid", res_valid, 0);
    check("idle_done_busy", busy, 0);

    sb.push_back('{ST_ABORT, 0, 1'b0});
    accept_req();
    check("abort_clr_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_clr_nostart", grid_start, 0);
    get_result("abort_clr", 0);

    accept_req();
    wait_start(lat);
    sb.push_back('{ST_ABORT, 5, 1'b1});
    repeat (5) tick();
    abort = 1'b1;
    done_failure = 1'b1;
    tick();
    abort = 1'b0;
    done_failure = 1'b0;
    get_result("abort_run", 0);

    accept_req();
    wait_start(lat);
`ifdef SOLVE_TIMEOUT_EN
    sb.push_back('{ST_TIMEOUT, TO - 1, 1'b1});
    get_result("timeout", 40);
`else
    sb.push_back('{ST_ABORT, 255, 1'b1});
    repeat (1000) tick();
    check("no_to_busy", busy, 1);
    check("no_to_valid", res_valid, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    get_result("sat", 0);
`endif

    accept_req();
    wait_start(lat);
    repeat (3) tick();
    #2 reset = 1'b0;
    #1 check_reset_vals("midrun");
    #3 reset = 1'b1;

    sb.push_back('{ST_FAILURE, 7, 1'b1});
    accept_req();
    wait_start(lat);
    repeat (7) tick();
    done_failure = 1'b1;
    tick();
    done_failure = 1'b0;
    get_result("fail", 0);

    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
